ddr_arbiter: RTL and testbench
==============================

# ddr_arbiter

Shares the single DDR3 Avalon-style master port (read/write, burst count, waitrequest, read-data-valid) between several core clients: ROM download writer, framebuffer writer, sprite/tile fetchers. It sits between the game core and the DDRAM top-level pins, clocked by `clk_sys`.

Grants are round-robin. A grant is held for one complete burst. At most one read burst is outstanding, so returned data always belongs to the current grant holder.

## Interface
Parameters:
- `NUM_CLIENTS`, 4: number of requesters (2..8).
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 64: data width.
- `BURST_W`, 8: burst count width.

Ports:
- `clk_sys` in 1: system clock. One clock; reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous active-low reset.
- `client_rd` in NUM_CLIENTS: per-client read request.
- `client_wr` in NUM_CLIENTS: per-client write request / write beat valid.
- `client_addr` in NUM_CLIENTS×ADDR_W: burst start address.
- `client_burst` in NUM_CLIENTS×BURST_W: beats in the burst.
- `client_din` in NUM_CLIENTS×DATA_W: write data.
- `client_be` in NUM_CLIENTS×DATA_W/8: write byte enables.
- `client_waitReq` out NUM_CLIENTS: per-client stall; low means the command or beat is accepted this cycle.
- `client_valid` out NUM_CLIENTS: read beat valid, routed to the grant holder only.
- `client_dout` out DATA_W: read data, broadcast to all clients.
- `ddr_rd`, `ddr_wr` out 1: DDR command strobes.
- `ddr_addr` out ADDR_W: DDR address.
- `ddr_burst` out BURST_W: DDR burst count.
- `ddr_din` out DATA_W: DDR write data.
- `ddr_be` out DATA_W/8: DDR byte enables.
- `ddr_waitReq`, `ddr_valid` in 1: DDR stall and read-data-valid.
- `ddr_dout` in DATA_W: DDR read data.

## Operation
- States: `IDLE`, `READ_CMD`, `READ_DATA`, `WRITE`.
- `IDLE`:
  - A client requests when `client_rd|client_wr` is high.
  - Round-robin search starts at `ptr`.
  - The winner index is registered in `grant`. Its address and burst are latched into `addr_q`/`burst_q`.
  - Next state is `READ_CMD` if `client_rd[grant]` is high, else `WRITE`. If a client asserts both, the read wins.
- A burst value of 0 is treated as 1.
- `READ_CMD`:
  - `ddr_rd`=1, `ddr_addr`=`addr_q`, `ddr_burst`=`burst_q`.
  - `client_waitReq[grant]`=`ddr_waitReq`.
  - When `ddr_waitReq`=0, go to `READ_DATA` with the beat counter cleared.
- `READ_DATA`:
  - `client_valid[grant]`=`ddr_valid`; `client_dout`=`ddr_dout`.
  - Each `ddr_valid` beat increments the counter.
  - On the beat where the counter reaches `burst_q`, go to `IDLE` and set `ptr`=`grant`+1, wrapping modulo NUM_CLIENTS.
- `WRITE`:
  - `ddr_wr`=`client_wr[grant]`; `ddr_din`/`ddr_be` pass through combinationally from the grant holder.
  - `ddr_addr`/`ddr_burst` are held at `addr_q`/`burst_q` for every beat.
  - A beat is accepted when `client_wr[grant]` & ~`ddr_waitReq`; `client_waitReq[grant]`=`ddr_waitReq`.
  - If `client_wr` is low mid-burst: `ddr_wr`=0, no beat is counted, and the grant is held.
  - On the last accepted beat, go to `IDLE` and advance `ptr` as for reads.
- Non-granted clients always see `client_waitReq`=1 and `client_valid`=0. In `IDLE`, every client sees `client_waitReq`=1.
- `ddr_valid` arriving outside `READ_DATA` is ignored and never routed.
- Clients must hold rd/wr, address and burst stable until accepted. Dropping a read request before acceptance is a protocol violation; behaviour is unspecified.

## Timing
- Reset values:
  - State `IDLE`; `grant`=0, `ptr`=0, counters 0.
  - `ddr_rd`=`ddr_wr`=0; `client_waitReq` all 1; `client_valid` all 0.
  - `ddr_addr`, `ddr_burst`, `ddr_din`, `ddr_be`, `client_dout` are don't-care but driven.
- Reset asserted mid-burst aborts immediately and asynchronously. The strobes drop the same instant.
- Latency:
  - A request seen in `IDLE` at cycle 0 puts the command on the DDR port at cycle 1.
  - The first write beat can be accepted at cycle 1.
- After the last beat there is one mandatory `IDLE` cycle, so back-to-back bursts are separated by exactly one cycle.
- Read data path is combinational: zero added latency from `ddr_valid` to `client_valid`.
- The beat counter is BURST_W+1 bits wide, so bursts up to 2^BURST_W−1 cannot overflow.

## Structure
- Package `cave_ddr_pkg`: state enum `ddr_arb_state_t`; default width constants `DDR_ADDR_W`, `DDR_DATA_W`, `DDR_BURST_W`.
- Sub-module `rr_arbiter`:
  - Purely combinational: takes the request vector and `ptr`, returns a one-hot grant and its index.
  - Unit-tested separately.
- Top level: state register, latches, beat counter and output muxing.

## Test plan
- Client 2 reads with burst 4 and `ddr_waitReq` low; DDR returns 4 beats 0xA0..0xA3 → `ddr_rd` high for exactly 1 cycle at cycle 1; `client_valid[2]` pulses 4 times with matching data; other valids stay 0; `ptr`=3 afterwards.
- Clients 0, 1 and 3 all request reads continuously, each burst 1 → grant order 0,1,3,0,…; one `IDLE` cycle between bursts.
- Client 1 writes burst 3 while `ddr_waitReq` is held high for 2 cycles on beat 2, and `client_wr` drops for 1 cycle → exactly 3 beats accepted; `ddr_addr` constant throughout; return to `IDLE` after beat 3.
- A client requests burst 0 → treated as a single-beat transfer.
- `reset_n` pulsed low during `READ_DATA` beat 2 of 8 → outputs return to reset values asynchronously; later stray `ddr_valid` beats produce no `client_valid`.
- Client 0 asserts both rd and wr → read transaction executes; `ddr_wr` stays 0.

Source files
------------

// File: rtl/cave_ddr_pkg.sv
// Shared types and default widths for the DDR arbiter slice.
package cave_ddr_pkg;

    localparam int unsigned DDR_ADDR_W  = 32;
    localparam int unsigned DDR_DATA_W  = 64;
    localparam int unsigned DDR_BURST_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StReadCmd,
        StReadData,
        StWrite
    } ddr_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    always_comb begin
        int unsigned j;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!gnt_valid && req[j]) begin
                gnt_valid = 1'b1;
                gnt[j]    = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ddr_arbiter.sv
// Round-robin arbiter sharing one Avalon-style DDR master port between core clients.
// One burst per grant; at most one read outstanding, so read data always belongs to the holder.
module ddr_arbiter
    import cave_ddr_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned ADDR_W      = DDR_ADDR_W,
    parameter int unsigned DATA_W      = DDR_DATA_W,
    parameter int unsigned BURST_W     = DDR_BURST_W
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,

    input  logic [NUM_CLIENTS-1:0]          client_rd,
    input  logic [NUM_CLIENTS-1:0]          client_wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]   client_addr,
    input  logic [NUM_CLIENTS*BURST_W-1:0]  client_burst,
    input  logic [NUM_CLIENTS*DATA_W-1:0]   client_din,
    input  logic [NUM_CLIENTS*DATA_W/8-1:0] client_be,
    output logic [NUM_CLIENTS-1:0]          client_waitReq,
    output logic [NUM_CLIENTS-1:0]          client_valid,
    output logic [DATA_W-1:0]               client_dout,

    output logic                          ddr_rd,
    output logic                          ddr_wr,
    output logic [ADDR_W-1:0]             ddr_addr,
    output logic [BURST_W-1:0]            ddr_burst,
    output logic [DATA_W-1:0]             ddr_din,
    output logic [DATA_W/8-1:0]           ddr_be,
    input  logic                          ddr_waitReq,
    input  logic                          ddr_valid,
    input  logic [DATA_W-1:0]             ddr_dout
);

    localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = BURST_W + 1;

    ddr_arb_state_t     state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_CLIENTS-1:0] arb_req;
    logic [NUM_CLIENTS-1:0] arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;

    logic [ADDR_W-1:0]  req_addr;
    logic [BURST_W-1:0] req_burst;
    logic               req_rd;
    logic               gnt_wr;
    logic [DATA_W-1:0]  gnt_din;
    logic [BE_W-1:0]    gnt_be;

    logic [CNT_W-1:0]   cnt_inc;
    logic               last_beat;
    logic [IDX_W-1:0]   ptr_next;

    assign arb_req = client_rd | client_wr;

    rr_arbiter #(
        .NUM_REQ (NUM_CLIENTS),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Request fields come from the arbiter winner; data path from the registered holder.
    always_comb begin
        req_addr  = '0;
        req_burst = '0;
        req_rd    = 1'b0;
        gnt_wr    = 1'b0;
        gnt_din   = '0;
        gnt_be    = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                req_addr  = client_addr[i*ADDR_W +: ADDR_W];
                req_burst = client_burst[i*BURST_W +: BURST_W];
                req_rd    = client_rd[i];
            end
            if (grant_q == IDX_W'(i)) begin
                gnt_wr  = client_wr[i];
                gnt_din = client_din[i*DATA_W +: DATA_W];
                gnt_be  = client_be[i*BE_W +: BE_W];
            end
        end
    end

    assign cnt_inc   = beat_cnt_q + CNT_W'(1);
    assign last_beat = (cnt_inc == {1'b0, burst_q});
    assign ptr_next  = (grant_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_q + IDX_W'(1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                beat_cnt_d = '0;
                if (arb_valid) begin
                    grant_d = arb_idx;
                    addr_d  = req_addr;
                    // A zero burst count is a single-beat transfer.
                    burst_d = (req_burst == '0) ? BURST_W'(1) : req_burst;
                    state_d = req_rd ? StReadCmd : StWrite;
                end
            end
            StReadCmd: begin
                if (!ddr_waitReq) begin
                    beat_cnt_d = '0;
                    state_d    = StReadData;
                end
            end
            StReadData: begin
                if (ddr_valid) begin
                    beat_cnt_d = cnt_inc;
                    if (last_beat) begin
                        state_d = StIdle;
                        ptr_d   = ptr_next;
                    end
                end
            end
            StWrite: begin
                if (gnt_wr && !ddr_waitReq) begin
                    beat_cnt_d = cnt_inc;
                    if (last_beat) begin
                        state_d = StIdle;
                        ptr_d   = ptr_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ddr_rd         = 1'b0;
        ddr_wr         = 1'b0;
        ddr_addr       = addr_q;
        ddr_burst      = burst_q;
        ddr_din        = gnt_din;
        ddr_be         = gnt_be;
        client_dout    = ddr_dout;
        client_waitReq = '1;
        client_valid   = '0;
        unique case (state_q)
            StIdle: ;
            StReadCmd: begin
                ddr_rd                  = 1'b1;
                client_waitReq[grant_q] = ddr_waitReq;
            end
            StReadData: begin
                client_valid[grant_q] = ddr_valid;
            end
            StWrite: begin
                ddr_wr                  = gnt_wr;
                client_waitReq[grant_q] = ddr_waitReq;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: reads, round-robin order, stalled writes, burst 0, async reset.
module tb_ddr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int EW = DW / 8;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      client_rd = '0;
    logic [N-1:0]      client_wr = '0;
    logic [N*AW-1:0]   client_addr = '0;
    logic [N*BW-1:0]   client_burst = '0;
    logic [N*DW-1:0]   client_din = '0;
    logic [N*EW-1:0]   client_be = '0;
    logic [N-1:0]      client_waitReq;
    logic [N-1:0]      client_valid;
    logic [DW-1:0]     client_dout;
    logic              ddr_rd;
    logic              ddr_wr;
    logic [AW-1:0]     ddr_addr;
    logic [BW-1:0]     ddr_burst;
    logic [DW-1:0]     ddr_din;
    logic [EW-1:0]     ddr_be;
    logic              ddr_waitReq = 1'b0;
    logic              ddr_valid = 1'b0;
    logic [DW-1:0]     ddr_dout = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    ddr_arbiter #(
        .NUM_CLIENTS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .BURST_W     (BW)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .client_rd      (client_rd),
        .client_wr      (client_wr),
        .client_addr    (client_addr),
        .client_burst   (client_burst),
        .client_din     (client_din),
        .client_be      (client_be),
        .client_waitReq (client_waitReq),
        .client_valid   (client_valid),
        .client_dout    (client_dout),
        .ddr_rd         (ddr_rd),
        .ddr_wr         (ddr_wr),
        .ddr_addr       (ddr_addr),
        .ddr_burst      (ddr_burst),
        .ddr_din        (ddr_din),
        .ddr_be         (ddr_be),
        .ddr_waitReq    (ddr_waitReq),
        .ddr_valid      (ddr_valid),
        .ddr_dout       (ddr_dout)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_client(input int idx, input logic [AW-1:0] addr, input logic [BW-1:0] burst,
                              input logic [DW-1:0] din, input logic [EW-1:0] be);
        client_addr[idx*AW +: AW]  = addr;
        client_burst[idx*BW +: BW] = burst;
        client_din[idx*DW +: DW]   = din;
        client_be[idx*EW +: EW]    = be;
    endtask

    task automatic apply_reset();
        client_rd   = '0;
        client_wr   = '0;
        ddr_valid   = 1'b0;
        ddr_waitReq = 1'b0;
        reset_n     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (client_waitReq !== 4'hF || client_valid !== 4'h0 || ddr_rd !== 1'b0 || ddr_wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: waitReq=%h valid=%h rd=%b wr=%b, want F 0 0 0",
                     client_waitReq, client_valid, ddr_rd, ddr_wr);
        end
        checks++;
        if (dut.ptr_q !== 2'd0 || dut.grant_q !== 2'd0) begin
            failures++;
            $display("FAIL reset_ptr_grant: ptr=%0d grant=%0d, want 0 0", dut.ptr_q, dut.grant_q);
        end
    endtask

    task automatic test_read_burst();
        set_client(2, 32'h0000_1200, 8'd4, '0, '0);
        client_rd[2] = 1'b1;
        #1;
        checks++;
        if (ddr_rd !== 1'b0 || client_waitReq !== 4'hF) begin
            failures++;
            $display("FAIL rd_idle: ddr_rd=%b waitReq=%h, want 0 F", ddr_rd, client_waitReq);
        end
        tick();
        checks++;
        if (ddr_rd !== 1'b1 || ddr_addr !== 32'h0000_1200 || ddr_burst !== 8'd4 ||
            client_waitReq !== 4'b1011) begin
            failures++;
            $display("FAIL rd_cmd: rd=%b addr=%h burst=%0d waitReq=%h, want 1 00001200 4 b",
                     ddr_rd, ddr_addr, ddr_burst, client_waitReq);
        end
        client_rd[2] = 1'b0;
        tick();
        checks++;
        if (ddr_rd !== 1'b0) begin
            failures++;
            $display("FAIL rd_cmd_once: ddr_rd=%b after accept, want 0", ddr_rd);
        end
        for (int b = 0; b < 4; b++) begin
            ddr_valid = 1'b1;
            ddr_dout  = 64'hA0 + 64'(b);
            #1;
            checks++;
            if (client_valid !== 4'b0100 || client_dout !== 64'hA0 + 64'(b)) begin
                failures++;
                $display("FAIL rd_beat%0d: valid=%b dout=%h, want 0100 %h",
                         b, client_valid, client_dout, 64'hA0 + 64'(b));
            end
            tick();
        end
        ddr_valid = 1'b0;
        #1;
        checks++;
        if (dut.ptr_q !== 2'd3 || client_waitReq !== 4'hF) begin
            failures++;
            $display("FAIL rd_done: ptr=%0d waitReq=%h, want 3 F", dut.ptr_q, client_waitReq);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 3, 0, 1};
        apply_reset();
        for (int c = 0; c < N; c++) set_client(c, 32'h100 * (c + 1), 8'd1, '0, '0);
        ddr_valid = 1'b1;
        ddr_dout  = 64'h55;
        client_rd = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] oh;
            oh = 4'b0001 << order[k];
            #1;
            checks++;
            if (client_waitReq !== 4'hF || ddr_rd !== 1'b0 || client_valid !== 4'h0) begin
                failures++;
                $display("FAIL rr_idle%0d: waitReq=%h rd=%b valid=%h, want F 0 0",
                         k, client_waitReq, ddr_rd, client_valid);
            end
            tick();
            checks++;
            if (ddr_rd !== 1'b1 || client_waitReq !== ~oh || ddr_addr !== 32'(32'h100 * (order[k] + 1))) begin
                failures++;
                $display("FAIL rr_cmd%0d: rd=%b waitReq=%h addr=%h, want 1 %h %h", k, ddr_rd,
                         client_waitReq, ddr_addr, ~oh, 32'h100 * (order[k] + 1));
            end
            tick();
            checks++;
            if (client_valid !== oh) begin
                failures++;
                $display("FAIL rr_data%0d: valid=%b, want %b", k, client_valid, oh);
            end
            tick();
        end
        client_rd = '0;
        ddr_valid = 1'b0;
        tick();
    endtask

    task automatic test_write_stall();
        int accepted = 0;
        logic [DW-1:0] din_seq[3] = '{64'hD0, 64'hD1, 64'hD2};
        // Per cycle: ddr_waitReq, client_wr, beat data index
        logic wreq_seq[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic cwr_seq[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   dix_seq[6]  = '{0, 1, 1, 1, 2, 2};
        set_client(1, 32'hCAFE_0000, 8'd3, din_seq[0], 8'h5A);
        client_wr[1] = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            ddr_waitReq  = wreq_seq[c];
            client_wr[1] = cwr_seq[c];
            client_din[1*DW +: DW] = din_seq[dix_seq[c]];
            #1;
            checks++;
            if (ddr_wr !== cwr_seq[c] || ddr_addr !== 32'hCAFE_0000 || ddr_burst !== 8'd3 ||
                ddr_din !== din_seq[dix_seq[c]] || ddr_be !== 8'h5A ||
                client_waitReq !== {2'b11, wreq_seq[c], 1'b1}) begin
                failures++;
                $display("FAIL wr_cycle%0d: wr=%b addr=%h burst=%0d din=%h be=%h waitReq=%h", c,
                         ddr_wr, ddr_addr, ddr_burst, ddr_din, ddr_be, client_waitReq);
            end
            if (ddr_wr && !ddr_waitReq) accepted++;
            tick();
        end
        client_wr   = '0;
        ddr_waitReq = 1'b0;
        #1;
        checks++;
        if (accepted != 3 || client_waitReq !== 4'hF || ddr_wr !== 1'b0) begin
            failures++;
            $display("FAIL wr_done: beats=%0d waitReq=%h wr=%b, want 3 F 0",
                     accepted, client_waitReq, ddr_wr);
        end
    endtask

    task automatic test_burst_zero();
        set_client(3, 32'h0000_3000, 8'd0, 64'hBEEF, 8'hFF);
        client_wr[3] = 1'b1;
        tick();
        checks++;
        if (ddr_wr !== 1'b1 || ddr_burst !== 8'd1 || client_waitReq !== 4'b0111) begin
            failures++;
            $display("FAIL b0_beat: wr=%b burst=%0d waitReq=%h, want 1 1 7",
                     ddr_wr, ddr_burst, client_waitReq);
        end
        tick();
        client_wr = '0;
        #1;
        checks++;
        if (ddr_wr !== 1'b0 || client_waitReq !== 4'hF) begin
            failures++;
            $display("FAIL b0_done: wr=%b waitReq=%h, want 0 F", ddr_wr, client_waitReq);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        set_client(0, 32'h0000_0800, 8'd8, '0, '0);
        client_rd[0] = 1'b1;
        tick();
        client_rd[0] = 1'b0;
        tick();
        ddr_valid = 1'b1;
        ddr_dout  = 64'h11;
        tick();
        ddr_dout = 64'h12;
        #1;
        checks++;
        if (client_valid !== 4'b0001) begin
            failures++;
            $display("FAIL rst_beat2: valid=%b, want 0001", client_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (client_valid !== 4'h0 || client_waitReq !== 4'hF || ddr_rd !== 1'b0 || ddr_wr !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: valid=%h waitReq=%h rd=%b wr=%b, want 0 F 0 0",
                     client_valid, client_waitReq, ddr_rd, ddr_wr);
        end
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (client_valid !== 4'h0 || ddr_rd !== 1'b0) begin
                failures++;
                $display("FAIL rst_stray%0d: valid=%h rd=%b, want 0 0", c, client_valid, ddr_rd);
            end
        end
        ddr_valid = 1'b0;
        tick();
    endtask

    task automatic test_rd_wr_both();
        apply_reset();
        set_client(0, 32'h0000_0040, 8'd1, 64'hFFFF, 8'hFF);
        client_rd[0] = 1'b1;
        client_wr[0] = 1'b1;
        tick();
        checks++;
        if (ddr_rd !== 1'b1 || ddr_wr !== 1'b0) begin
            failures++;
            $display("FAIL both_cmd: rd=%b wr=%b, want 1 0", ddr_rd, ddr_wr);
        end
        client_rd[0] = 1'b0;
        client_wr[0] = 1'b0;
        tick();
        ddr_valid = 1'b1;
        ddr_dout  = 64'h77;
        #1;
        checks++;
        if (client_valid !== 4'b0001 || ddr_wr !== 1'b0 || client_dout !== 64'h77) begin
            failures++;
            $display("FAIL both_data: valid=%b wr=%b dout=%h, want 0001 0 77",
                     client_valid, ddr_wr, client_dout);
        end
        tick();
        ddr_valid = 1'b0;
        #1;
        checks++;
        if (client_waitReq !== 4'hF || ddr_wr !== 1'b0) begin
            failures++;
            $display("FAIL both_done: waitReq=%h wr=%b, want F 0", client_waitReq, ddr_wr);
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_round_robin();
        test_write_stall();
        test_burst_zero();
        test_reset_mid_burst();
        test_rd_wr_both();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
